// File: rtl/cavlc_bit_serializer_if.sv
// rtl/cavlc_bit_serializer_if.sv - request/bitstream bundle between controller, serializer and bit FIFO
interface cavlc_bit_serializer_if #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
);
  logic               start;
  logic [MAX_LEN-1:0] data_in;
  logic [LEN_W-1:0]   len_in;
  logic               msb_first;
  logic               fifo_full;
  logic               fifo_push;
  logic               fifo_data;
  logic               busy;
  logic               done;

  modport master (
    output start, data_in, len_in, msb_first, fifo_full,
    input  fifo_push, fifo_data, busy, done
  );

  modport slave (
    input  start, data_in, len_in, msb_first, fifo_full,
    output fifo_push, fifo_data, busy, done
  );
endinterface

// File: rtl/cavlc_bit_serializer.sv
// rtl/cavlc_bit_serializer.sv - serializes a right-aligned field one bit per cycle into a bit FIFO
// Optional FIFO back-pressure stalls are enabled by defining CAVLC_SER_BACKPRESSURE_EN.
module cavlc_bit_serializer #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input logic                  clk,
  input logic                  rst,
  cavlc_bit_serializer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_e             state_q;
  logic [MAX_LEN-1:0] shift_q;
  logic [LEN_W-1:0]   count_q;
  logic               msb_q;
  logic               push_q;
  logic               data_q;
  logic               busy_q;
  logic               done_q;

  logic               stall;
  logic [LEN_W-1:0]   len_clamped;
  logic [MAX_LEN-1:0] load_val;
  logic               next_bit;

`ifdef CAVLC_SER_BACKPRESSURE_EN
  assign stall = bus.fifo_full;
`else
  logic unused_fifo_full;
  assign unused_fifo_full = bus.fifo_full;
  assign stall            = 1'b0;
`endif

  // MSB-first fields are left-aligned at load so both orders shift out of a fixed end.
  always_comb begin
    len_clamped = (bus.len_in > MAX_LEN_L) ? MAX_LEN_L : bus.len_in;
    load_val    = bus.msb_first ? (bus.data_in << (MAX_LEN_L - len_clamped)) : bus.data_in;
    next_bit    = msb_q ? shift_q[MAX_LEN-1] : shift_q[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      msb_q   <= 1'b0;
      push_q  <= 1'b0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          push_q <= 1'b0;
          data_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.start) begin
            shift_q <= load_val;
            msb_q   <= bus.msb_first;
            count_q <= len_clamped;
            busy_q  <= 1'b1;
            state_q <= (len_clamped != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          done_q <= 1'b0;
          if (stall) begin
            push_q <= 1'b0;
          end else begin
            push_q  <= 1'b1;
            data_q  <= next_bit;
            shift_q <= msb_q ? (shift_q << 1) : (shift_q >> 1);
            count_q <= count_q - LEN_W'(1);
            if (count_q == LEN_W'(1)) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          push_q  <= 1'b0;
          data_q  <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          push_q  <= 1'b0;
          data_q  <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.fifo_push = push_q;
  assign bus.fifo_data = data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_cavlc_bit_serializer.sv
// tb/tb_cavlc_bit_serializer.sv - randomized self-checking bench for cavlc_bit_serializer
module tb_cavlc_bit_serializer;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
`ifdef CAVLC_SER_BACKPRESSURE_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  cavlc_bit_serializer_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

  cavlc_bit_serializer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request in the current cycle and follows it to its done pulse.
  // full_mask bit c is fifo_full during cycle c (cycle 0 = start cycle).
  task automatic run_req(input string tag, input logic [15:0] d, input int len, input bit msb,
                         input logic [63:0] full_mask, input int repulse, output int done_cyc);
    int          n;
    int          rem;
    int          stalls;
    int          npush;
    int          ndone;
    int          cyc;
    bit          prev_stall;
    logic [31:0] exp_bits;
    logic [31:0] got_bits;

    n        = (len > MAX_LEN) ? MAX_LEN : len;
    exp_bits = '0;
    got_bits = '0;
    for (int i = 0; i < n; i++) exp_bits[i] = msb ? d[n-1-i] : d[i];

    bus.start     = 1'b1;
    bus.data_in   = d;
    bus.len_in    = 5'(len);
    bus.msb_first = msb;
    bus.fifo_full = full_mask[0];
    rem = n; stalls = 0; npush = 0; ndone = 0; done_cyc = -1; cyc = 0;

    while (cyc < 150 && ndone == 0) begin
      prev_stall = 1'b0;
      if (cyc >= 1 && rem > 0) begin
        if (STALL_EN && bus.fifo_full) begin
          stalls++;
          prev_stall = 1'b1;
        end else begin
          rem--;
        end
      end
      step();
      cyc++;
      if (cyc == repulse) begin
        bus.start     = 1'b1;
        bus.data_in   = ~d;
        bus.len_in    = 5'd3;
        bus.msb_first = ~msb;
      end else begin
        bus.start = 1'b0;
      end
      bus.fifo_full = (cyc < 64) ? full_mask[cyc] : 1'b0;

      if (bus.fifo_push) begin
        if (npush < 32) got_bits[npush] = bus.fifo_data;
        npush++;
      end else if (!prev_stall) begin
        check_eq({tag, "_idle_data"}, {31'd0, bus.fifo_data}, 32'd0);
      end
      if (bus.done) begin
        ndone++;
        done_cyc = cyc;
        check_eq({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
      end else begin
        check_eq({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      end
    end

    bus.start     = 1'b0;
    bus.fifo_full = 1'b0;
    check_eq({tag, "_done_seen"}, ndone, 1);
    check_eq({tag, "_npush"}, npush, n);
    check_eq({tag, "_bits"}, got_bits, exp_bits);
    check_eq({tag, "_latency"}, done_cyc, n + 2 + stalls);
  endtask

  initial begin
    int          dc;
    int          len;
    int          rp;
    int          quiet;
    logic [63:0] fm;

    checks   = 0;
    failures = 0;

    // Reset held with start and fifo_full asserted: reset must win.
    rst           = 1'b1;
    bus.start     = 1'b1;
    bus.data_in   = 16'hFFFF;
    bus.len_in    = 5'd5;
    bus.msb_first = 1'b0;
    bus.fifo_full = 1'b1;
    repeat (3) step();
    check_eq("rst_push", {31'd0, bus.fifo_push}, 32'd0);
    check_eq("rst_data", {31'd0, bus.fifo_data}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_done", {31'd0, bus.done}, 32'd0);
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.fifo_full = 1'b0;
    step();
    check_eq("post_rst_busy", {31'd0, bus.busy}, 32'd0);

    // Directed cases
    run_req("lsb3", 16'h0005, 3, 1'b0, 64'd0, 0, dc);
    check_eq("lsb3_done5", dc, 5);
    step();
    run_req("msb3", 16'h0006, 3, 1'b1, 64'd0, 0, dc);
    run_req("len0", 16'hABCD, 0, 1'b1, 64'd0, 0, dc);
    check_eq("len0_done2", dc, 2);
    step();
    run_req("stall4", 16'h000B, 4, 1'b1, 64'b1100, 0, dc);
    check_eq("stall4_done", dc, STALL_EN ? 8 : 6);
    step();
    run_req("clamp", 16'hFFFF, 20, 1'b0, 64'd0, 5, dc);

    // Reset in the middle of a field
    step();
    bus.start     = 1'b1;
    bus.data_in   = 16'($urandom);
    bus.len_in    = 5'd8;
    bus.msb_first = 1'($urandom);
    step();
    bus.start = 1'b0;
    step();
    check_eq("abort_push1", {31'd0, bus.fifo_push}, 32'd1);
    step();
    check_eq("abort_push2", {31'd0, bus.fifo_push}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("abort_push", {31'd0, bus.fifo_push}, 32'd0);
    check_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("abort_done", {31'd0, bus.done}, 32'd0);
    quiet = 0;
    repeat (12) begin
      step();
      quiet += int'(bus.fifo_push) + int'(bus.done) + int'(bus.busy);
    end
    check_eq("abort_quiet", quiet, 0);
    run_req("after_abort", 16'h00A5, 8, 1'b1, 64'd0, 0, dc);

    // Randomized requests, mixing back-to-back starts with idle gaps
    for (int t = 0; t < 40; t++) begin
      len = $urandom_range(0, 20);
      fm  = {$urandom, $urandom} & {$urandom, $urandom};
      rp  = (len > 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, (len > MAX_LEN) ? MAX_LEN : len) : 0;
      run_req("rnd", 16'($urandom), len, 1'($urandom), fm, rp, dc);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cavlc_bit_serializer.md
CAVLC_BIT_SERIALIZER -- requirements
Module: cavlc_bit_serializer

Interface
REQ-001 Parameter MAX_LEN, default 16, meaning maximum field length in bits accepted per request (range 1..32).
REQ-002 Parameter LEN_W, default 5, meaning width of len_in (SHALL satisfy 2^LEN_W > MAX_LEN).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request pulse; sampled only in IDLE.
REQ-006 data_in  input  MAX_LEN  field bits, right-aligned (bit 0 = LSB of field).
REQ-007 len_in  input  LEN_W  number of field bits to emit (0..MAX_LEN).
REQ-008 msb_first  input  1  1 = emit bit len_in-1 first, down to bit 0; 0 = emit bit 0 first, up to bit len_in-1.
REQ-009 fifo_full  input  1  downstream bitstream FIFO full flag.
REQ-010 fifo_push  output  1  registered write strobe, one bit per asserted cycle.
REQ-011 fifo_data  output  1  registered bit written when fifo_push=1.
REQ-012 busy  output  1  high while a request is being processed (states SHIFT, DONE).
REQ-013 done  output  1  registered one-cycle completion pulse to the main controller.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-015 IDLE with start=1: data_in, msb_first latched; remaining count loaded with min(len_in, MAX_LEN); next state SHIFT if count>0, else DONE.
REQ-016 len_in > MAX_LEN SHALL be clamped to MAX_LEN.
REQ-017 SHIFT, not stalled: fifo_push<=1, fifo_data<=next bit in selected order, remaining decremented; when remaining reaches 0, next state DONE.
REQ-018 SHIFT, stalled: fifo_push<=0, fifo_data holds, no shift, no decrement.
REQ-019 First fifo_push SHALL appear in the second cycle after the start cycle (start edge -> SHIFT; first SHIFT edge -> push visible).
REQ-020 DONE: fifo_push<=0, done<=1 for exactly one cycle, next state IDLE.
REQ-021 Total latency SHALL be len+2 cycles from start to done with no stalls; len=0 gives done 2 cycles after start, zero pushes.
REQ-022 start while busy=1 SHALL be ignored and SHALL NOT corrupt the in-flight field.
REQ-023 Bits above len_in-1 in data_in SHALL never be emitted.
REQ-024 fifo_data SHALL be 0 whenever fifo_push=0 outside a stall.
REQ-025 start in the same cycle done is high SHALL be accepted (back-to-back requests, no idle gap required beyond DONE).

Reset
REQ-026 rst=1 at any edge: state IDLE, fifo_push=0, fifo_data=0, busy=0, done=0, shift register and counter cleared.
REQ-027 rst asserted mid-SHIFT SHALL abort the field; no further pushes and no done pulse for it.
REQ-028 rst SHALL take priority over start and fifo_full.

Configuration
REQ-029 Macro CAVLC_SER_BACKPRESSURE_EN SHALL control stall behaviour.
REQ-030 Defined: SHIFT is stalled on any edge where fifo_full=1 (REQ-018 applies).
REQ-031 Undefined: fifo_full port remains present but is ignored; SHIFT never stalls; latency always len+2.

Verification
REQ-032 data_in=0x0005, len_in=3, msb_first=0, no full -> pushes 1,0,1 on cycles 2..4, done at cycle 5.
REQ-033 data_in=0x0006, len_in=3, msb_first=1 -> pushes 1,1,0; then len_in=0 -> no push, done 2 cycles after start.
REQ-034 (macro defined) data_in=0xB, len_in=4, msb_first=1, fifo_full high for 2 cycles after first push -> sequence 1,0,1,1 intact, done at cycle 8; (macro undefined) same stimulus -> done at cycle 6.
REQ-035 len_in=20 with MAX_LEN=16, data_in=0xFFFF -> exactly 16 pushes of 1; start pulsed again mid-field -> ignored, count unchanged.
REQ-036 rst pulsed after second push of a len=8 field -> fifo_push=0 next cycle, no done, busy=0; new start then processes normally.
